fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the 256x32 combinational instruction memory.
- Owns the 8-bit program counter and drives the memory address.
- Registers the returned 32-bit word into an instruction register for the decode stage, with its PC and a valid flag.
- Handles stall from downstream, redirect (jump) from execute, and a halt request.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, pipeline control inputs and the decode-side outputs.
interface fetch_unit_if;
  logic [7:0]  i_addr;
  logic [31:0] i_data;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halt_req;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  modport master (
    output i_addr, instr, instr_pc, instr_valid, halted,
    input  i_data, stall, jump_en, jump_addr, halt_req
  );

  modport slave (
    input  i_addr, instr, instr_pc, instr_valid, halted,
    output i_data, stall, jump_en, jump_addr, halt_req
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the memory word for decode, and handles stall/jump/halt.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [31:0] NOP_WORD = 32'h00360000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;

  assign bus.i_addr      = pc;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= NOP_WORD;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          instr       <= NOP_WORD;
          instr_valid <= 1'b0;
          state       <= RUN;
          if (bus.jump_en) pc <= bus.jump_addr;
        end
        RUN: begin
          // Jump and halt both squash the word on the bus this cycle, even under stall.
          if (bus.jump_en) begin
            pc          <= bus.jump_addr;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
          end else if (bus.halt_req) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            state       <= HALT;
          end else if (!bus.stall) begin
            instr       <= bus.i_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 8'd1;
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
          if (bus.jump_en) begin
            pc    <= bus.jump_addr;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: combinational memory model and hand-derived expected values.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00360000;

  logic clk = 1'b0;
  logic rst_n;
  fetch_unit_if bus ();

  logic [31:0] mem [256];
  int unsigned checks = 0;
  int unsigned failures = 0;

  fetch_unit #(.RESET_PC(8'h00), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_data = mem[bus.i_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] addr, input logic valid,
                            input logic [7:0] ipc, input logic [31:0] word, input logic hlt);
    check({tag, ".i_addr"},      {24'h0, bus.i_addr},      {24'h0, addr});
    check({tag, ".instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, valid});
    check({tag, ".instr_pc"},    {24'h0, bus.instr_pc},    {24'h0, ipc});
    check({tag, ".instr"},       bus.instr,                word);
    check({tag, ".halted"},      {31'h0, bus.halted},      {31'h0, hlt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[0] = 32'h0036e000;
    mem[1] = 32'h0036e104;
    mem[2] = 32'h0010e001;
    mem[3] = 32'h00120201;
    mem[4] = 32'h00500003;
    mem[5] = 32'h0036e205;

    rst_n = 1'b0; bus.stall = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = '0; bus.halt_req = 1'b0;
    step(); step();
    expect_out("reset", 8'h00, 1'b0, 8'h00, NOP, 1'b0);

    rst_n = 1'b1;
    step();
    expect_out("boot", 8'h00, 1'b0, 8'h00, NOP, 1'b0);
    step(); expect_out("run0", 8'h01, 1'b1, 8'h00, 32'h0036e000, 1'b0);
    step(); expect_out("run1", 8'h02, 1'b1, 8'h01, 32'h0036e104, 1'b0);
    step(); expect_out("run2", 8'h03, 1'b1, 8'h02, 32'h0010e001, 1'b0);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 8'h03, 1'b1, 8'h02, 32'h0010e001, 1'b0);
    end
    bus.stall = 1'b0;
    step(); expect_out("unstall", 8'h04, 1'b1, 8'h03, mem[3], 1'b0);
    step(); expect_out("run4", 8'h05, 1'b1, 8'h04, mem[4], 1'b0);

    bus.jump_en = 1'b1; bus.jump_addr = 8'h02; bus.stall = 1'b1;
    step(); expect_out("jump_stall", 8'h02, 1'b0, 8'h04, NOP, 1'b0);
    bus.jump_en = 1'b0; bus.stall = 1'b0;
    step(); expect_out("after_jump", 8'h03, 1'b1, 8'h02, 32'h0010e001, 1'b0);

    bus.jump_en = 1'b1; bus.jump_addr = 8'hFE;
    step(); expect_out("jump_fe", 8'hFE, 1'b0, 8'h02, NOP, 1'b0);
    bus.jump_en = 1'b0;
    step(); expect_out("wrap_fe", 8'hFF, 1'b1, 8'hFE, mem[254], 1'b0);
    step(); expect_out("wrap_ff", 8'h00, 1'b1, 8'hFF, mem[255], 1'b0);
    step(); expect_out("wrap_00", 8'h01, 1'b1, 8'h00, 32'h0036e000, 1'b0);

    bus.jump_en = 1'b1; bus.jump_addr = 8'h04;
    step(); expect_out("jump_4", 8'h04, 1'b0, 8'h00, NOP, 1'b0);
    bus.jump_en = 1'b0; bus.halt_req = 1'b1;
    step(); expect_out("halt_entry", 8'h04, 1'b0, 8'h00, NOP, 1'b1);
    bus.halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0];
      bus.halt_req = i[1];
      step(); expect_out("halted", 8'h04, 1'b0, 8'h00, NOP, 1'b1);
    end
    bus.stall = 1'b0; bus.halt_req = 1'b0;
    bus.jump_en = 1'b1; bus.jump_addr = 8'h00;
    step(); expect_out("halt_exit", 8'h00, 1'b0, 8'h00, NOP, 1'b0);
    bus.jump_en = 1'b0;
    step(); expect_out("resume0", 8'h01, 1'b1, 8'h00, 32'h0036e000, 1'b0);
    step(); expect_out("resume1", 8'h02, 1'b1, 8'h01, 32'h0036e104, 1'b0);

    rst_n = 1'b0; bus.jump_en = 1'b1; bus.jump_addr = 8'h80;
    step(); expect_out("mid_reset", 8'h00, 1'b0, 8'h00, NOP, 1'b0);
    rst_n = 1'b1; bus.jump_en = 1'b0;
    step(); expect_out("mid_boot", 8'h00, 1'b0, 8'h00, NOP, 1'b0);
    step(); expect_out("mid_run0", 8'h01, 1'b1, 8'h00, 32'h0036e000, 1'b0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'h10;
    step(); expect_out("boot_jump", 8'h10, 1'b0, 8'h00, NOP, 1'b0);
    bus.jump_en = 1'b0;
    step(); expect_out("boot_jump_run", 8'h11, 1'b1, 8'h10, mem[16], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
